// File: rtl/anneal_run_sequencer_if.sv
// Control, spin-RF and analog-strobe bundle of the anneal run sequencer.
// The master modport is the sequencer; the slave modport is its surroundings
// (config registers, the two spin RFs and the analog top).
interface anneal_run_sequencer_if #(
    parameter int NUM_SPINS = 50,
    parameter int ISPIN_AW  = 7,
    parameter int OSPIN_AW  = 8
);
    logic                 i_start;
    logic                 i_abort;
    logic [7:0]           i_total_run_count;
    logic [7:0]           i_run_time_interval;
    logic [1:0]           i_fix_langevin_sel;
    logic [ISPIN_AW-1:0]  o_ispin_a;
    logic                 o_ispin_web;
    logic [NUM_SPINS-1:0] i_ispin_q;
    logic [OSPIN_AW-1:0]  o_ospin_a;
    logic                 o_ospin_web;
    logic [NUM_SPINS-1:0] o_ospin_d;
    logic [NUM_SPINS-1:0] o_ospin_bweb;
    logic [NUM_SPINS-1:0] i_spin_read_out;
    logic [NUM_SPINS-1:0] o_spin_init_condition;
    logic                 o_spin_pre_prog_ic;
    logic                 o_spin_prog_ic;
    logic                 o_spin_CCII_ena;
    logic                 o_spin_read_out_ena;
    logic                 o_spin_fix_ena;
    logic                 o_langevin_ena;
    logic [7:0]           o_run_counter;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_ospin_overflow;

    modport master (
        input  i_start, i_abort, i_total_run_count, i_run_time_interval,
               i_fix_langevin_sel, i_ispin_q, i_spin_read_out,
        output o_ispin_a, o_ispin_web, o_ospin_a, o_ospin_web, o_ospin_d,
               o_ospin_bweb, o_spin_init_condition, o_spin_pre_prog_ic,
               o_spin_prog_ic, o_spin_CCII_ena, o_spin_read_out_ena,
               o_spin_fix_ena, o_langevin_ena, o_run_counter, o_busy,
               o_done, o_ospin_overflow
    );

    modport slave (
        output i_start, i_abort, i_total_run_count, i_run_time_interval,
               i_fix_langevin_sel, i_ispin_q, i_spin_read_out,
        input  o_ispin_a, o_ispin_web, o_ospin_a, o_ospin_web, o_ospin_d,
               o_ospin_bweb, o_spin_init_condition, o_spin_pre_prog_ic,
               o_spin_prog_ic, o_spin_CCII_ena, o_spin_read_out_ena,
               o_spin_fix_ena, o_langevin_ena, o_run_counter, o_busy,
               o_done, o_ospin_overflow
    );
endinterface

// File: rtl/anneal_run_sequencer.sv
// Anneal run sequencer: steps the Ising core through a batch of anneal runs.
// Each run fetches its initial spin vector, walks the analog phase strobes
// (pre-program, program, CCII anneal, read-out) and stores the read-out spins
// into output_spin_rf at the run index. Phase strobes are flops whose next
// value is decoded from the next state, so each strobe lines up exactly with
// its state. The RF write port is decoded from the current state so the data
// is the read-out sampled during CAPTURE and an abort in that cycle can veto it.
module anneal_run_sequencer #(
    parameter int NUM_SPINS   = 50,
    parameter int ISPIN_AW    = 7,
    parameter int OSPIN_AW    = 8,
    parameter int OSPIN_DEPTH = 200,
    parameter int PREPROG_CYC = 4,
    parameter int PROG_CYC    = 8,
    parameter int SETTLE_CYC  = 2
) (
    input logic                    i_clk,
    input logic                    i_rst,
    anneal_run_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LATCH, S_PREPROG, S_PROG,
        S_ANNEAL, S_READOUT, S_CAPTURE, S_NEXT, S_DONE
    } state_e;

    localparam logic [8:0] DEPTH_W = 9'(OSPIN_DEPTH);

    state_e               state_q, state_d;
    logic [7:0]           phase_cnt_q, phase_cnt_d;
    logic [7:0]           run_counter_q, run_counter_d;
    logic [7:0]           count_q, count_d;
    logic [7:0]           interval_q, interval_d;
    logic [1:0]           sel_q, sel_d;
    logic                 overflow_q, overflow_d;
    logic [NUM_SPINS-1:0] init_q, init_d;
    logic [ISPIN_AW-1:0]  ispin_a_q, ispin_a_d;
    logic                 pre_prog_q, pre_prog_d;
    logic                 prog_q, prog_d;
    logic                 ccii_q, ccii_d;
    logic                 read_out_q, read_out_d;
    logic                 fix_q, fix_d;
    logic                 lang_q, lang_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 in_range;
    logic                 write_en;

    assign in_range = ({1'b0, run_counter_q} < DEPTH_W);
    assign write_en = (state_q == S_CAPTURE) && in_range && !bus.i_abort && !i_rst;

    // Next-state, phase counting and registered-output decode.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would infer a latch.
        state_d       = state_q;
        phase_cnt_d   = phase_cnt_q;
        run_counter_d = run_counter_q;
        count_d       = count_q;
        interval_d    = interval_q;
        sel_d         = sel_q;
        overflow_d    = overflow_q;
        init_d        = init_q;

        if (state_q != S_IDLE && bus.i_abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.i_start && !bus.i_abort) begin
                        count_d       = bus.i_total_run_count;
                        interval_d    = bus.i_run_time_interval;
                        sel_d         = bus.i_fix_langevin_sel;
                        run_counter_d = '0;
                        overflow_d    = 1'b0;
                        state_d       = (bus.i_total_run_count == 8'd0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: state_d = S_LATCH;
                S_LATCH: begin
                    init_d      = bus.i_ispin_q;
                    phase_cnt_d = 8'(PREPROG_CYC - 1);
                    state_d     = S_PREPROG;
                end
                S_PREPROG: begin
                    if (phase_cnt_q == 8'd0) begin
                        phase_cnt_d = 8'(PROG_CYC - 1);
                        state_d     = S_PROG;
                    end else begin
                        phase_cnt_d = phase_cnt_q - 8'd1;
                    end
                end
                S_PROG: begin
                    if (phase_cnt_q == 8'd0) begin
                        phase_cnt_d = interval_q;
                        state_d     = S_ANNEAL;
                    end else begin
                        phase_cnt_d = phase_cnt_q - 8'd1;
                    end
                end
                S_ANNEAL: begin
                    if (phase_cnt_q == 8'd0) begin
                        phase_cnt_d = 8'(SETTLE_CYC - 1);
                        state_d     = S_READOUT;
                    end else begin
                        phase_cnt_d = phase_cnt_q - 8'd1;
                    end
                end
                S_READOUT: begin
                    if (phase_cnt_q == 8'd0) begin
                        state_d = S_CAPTURE;
                    end else begin
                        phase_cnt_d = phase_cnt_q - 8'd1;
                    end
                end
                S_CAPTURE: begin
                    if (!in_range) begin
                        overflow_d = 1'b1;
                    end
                    state_d = S_NEXT;
                end
                S_NEXT: begin
                    run_counter_d = run_counter_q + 8'd1;
                    state_d       = (run_counter_d == count_q) ? S_DONE : S_FETCH;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        ispin_a_d  = (state_d == S_FETCH) ? ISPIN_AW'(run_counter_d) : '0;
        pre_prog_d = (state_d == S_PREPROG);
        prog_d     = (state_d == S_PROG);
        ccii_d     = (state_d == S_ANNEAL) || (state_d == S_READOUT);
        read_out_d = (state_d == S_READOUT) || (state_d == S_CAPTURE);
        fix_d      = ccii_d && sel_d[1];
        lang_d     = ccii_d && sel_d[0];
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            state_q       <= S_IDLE;
            phase_cnt_q   <= '0;
            run_counter_q <= '0;
            count_q       <= '0;
            interval_q    <= '0;
            sel_q         <= '0;
            overflow_q    <= 1'b0;
            init_q        <= '0;
            ispin_a_q     <= '0;
            pre_prog_q    <= 1'b0;
            prog_q        <= 1'b0;
            ccii_q        <= 1'b0;
            read_out_q    <= 1'b0;
            fix_q         <= 1'b0;
            lang_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_cnt_q   <= phase_cnt_d;
            run_counter_q <= run_counter_d;
            count_q       <= count_d;
            interval_q    <= interval_d;
            sel_q         <= sel_d;
            overflow_q    <= overflow_d;
            init_q        <= init_d;
            ispin_a_q     <= ispin_a_d;
            pre_prog_q    <= pre_prog_d;
            prog_q        <= prog_d;
            ccii_q        <= ccii_d;
            read_out_q    <= read_out_d;
            fix_q         <= fix_d;
            lang_q        <= lang_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.o_ispin_a             = ispin_a_q;
    assign bus.o_ispin_web           = 1'b1;
    assign bus.o_ospin_web           = !write_en;
    assign bus.o_ospin_a             = write_en ? OSPIN_AW'(run_counter_q) : '0;
    assign bus.o_ospin_d             = write_en ? bus.i_spin_read_out : '0;
    assign bus.o_ospin_bweb          = write_en ? '0 : '1;
    assign bus.o_spin_init_condition = init_q;
    assign bus.o_spin_pre_prog_ic    = pre_prog_q;
    assign bus.o_spin_prog_ic        = prog_q;
    assign bus.o_spin_CCII_ena       = ccii_q;
    assign bus.o_spin_read_out_ena   = read_out_q;
    assign bus.o_spin_fix_ena        = fix_q;
    assign bus.o_langevin_ena        = lang_q;
    assign bus.o_run_counter         = run_counter_q;
    assign bus.o_busy                = busy_q;
    assign bus.o_done                = done_q;
    assign bus.o_ospin_overflow      = overflow_q;
endmodule
